// File: rtl/reg_cmd_host.sv
// Command initiator for the register file: buffers commands in a FIFO, issues each as a
// one-cycle reg_ena pulse and returns OUT results on a valid/ready response port.
module reg_cmd_host #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       reg_ena,
    output logic [2:0] reg_opcode,
    output logic [7:0] reg_data,
    input  logic [7:0] reg_rdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_src,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUED, CAPTURE, RESP} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state, state_nxt;
    logic [10:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;
    logic [10:0]      head;

    logic             ena_nxt;
    logic [2:0]       op_nxt;
    logic [7:0]       data_nxt;
    logic             rsp_valid_nxt;
    logic [7:0]       rsp_data_nxt;
    logic             rsp_src_nxt;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rptr];
    assign busy      = (state != IDLE) || !empty;

    // Command FIFO: storage is data only, pointers and count are control
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= {cmd_op, cmd_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue / capture sequencing
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        ena_nxt       = 1'b0;
        op_nxt        = reg_opcode;
        data_nxt      = reg_data;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_src_nxt   = rsp_src;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    ena_nxt  = 1'b1;
                    op_nxt   = head[10:8];
                    data_nxt = head[7:0];
                    // Only OUT opcodes (10x) wait for a result; others stream back-to-back
                    if (head[10:9] == 2'b10) state_nxt = ISSUED;
                end
            end
            ISSUED: state_nxt = CAPTURE;
            CAPTURE: begin
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = reg_rdata;
                rsp_src_nxt   = reg_opcode[0];
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            reg_ena    <= 1'b0;
            reg_opcode <= 3'b000;
            reg_data   <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_src    <= 1'b0;
        end else begin
            state      <= state_nxt;
            reg_ena    <= ena_nxt;
            reg_opcode <= op_nxt;
            reg_data   <= data_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_src    <= rsp_src_nxt;
        end
    end
endmodule
